cache_fill_fsm: RTL and testbench

Miss-handling controller between a cache's tag/data arrays and the multi-cycle main memory that replaces the single-cycle `memory1c` instances feeding the pipeline's IF and MEM stages. On a miss, it issues one read per word of the missing line and writes each returned word into the data array. On the final word it writes the tag array, then frees the cache. The pipeline stalls on `fsm_busy`. One instance serves the I-cache and one serves the D-cache.

---
 rtl/cache_fill_fsm_pkg.sv | 22 ++
 rtl/cache_fill_fsm_if.sv | 36 +++
 rtl/cache_fill_fsm_fill_counter.sv | 28 ++
 rtl/cache_fill_fsm.sv | 99 +++++++++
 tb/tb_cache_fill_fsm.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_fill_fsm_pkg.sv
// Shared constants and types for the cache line-fill controller and the memory model
// that feeds it.
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam int BYTES_PER_WORD     = 2;
  localparam int WORD_W             = 16;
  localparam int DEFAULT_LINE_WORDS = 8;
  localparam int DEFAULT_ADDR_W     = 16;

  // Width of the byte offset inside one cache line.
  function automatic int offset_w(input int line_words);
    return $clog2(line_words * BYTES_PER_WORD);
  endfunction

  localparam int DEFAULT_OFFSET_W = offset_w(DEFAULT_LINE_WORDS);

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Cache/memory-side bundle of the line-fill controller. The master is the fill FSM.
// The slave is the cache arrays plus the main memory.
interface cache_fill_fsm_if
  import cache_fill_fsm_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int ADDR_W     = DEFAULT_ADDR_W
);
  localparam int IDX_W = $clog2(LINE_WORDS);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_valid;
  logic [WORD_W-1:0] memory_data_in;
  logic              fsm_busy;
  logic              mem_req;
  logic [ADDR_W-1:0] memory_address;
  logic              write_data_array;
  logic [IDX_W-1:0]  fill_word_idx;
  logic [WORD_W-1:0] fill_data;
  logic              write_tag_array;
  logic [ADDR_W-1:0] fill_base_addr;

  modport master (
    input  miss_detected, miss_address, memory_valid, memory_data_in,
    output fsm_busy, mem_req, memory_address, write_data_array,
           fill_word_idx, fill_data, write_tag_array, fill_base_addr
  );

  modport slave (
    output miss_detected, miss_address, memory_valid, memory_data_in,
    input  fsm_busy, mem_req, memory_address, write_data_array,
           fill_word_idx, fill_data, write_tag_array, fill_base_addr
  );

endinterface

// File: rtl/cache_fill_fsm_fill_counter.sv
// Up-counter with synchronous clear and increment enable. The fill FSM uses one for
// issued requests and one for received words.
module fill_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // NOTE: clocked state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_fill_fsm.sv
// Line-fill controller: on a miss it requests every word of the line and writes each
// returned word. The tag is written with the last word.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int LINE_WORDS = DEFAULT_LINE_WORDS,
  parameter int ADDR_W     = DEFAULT_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_fill_fsm_if.master bus
);

  localparam int IDX_W = $clog2(LINE_WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam int OFF_W = offset_w(LINE_WORDS);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

  fill_state_e       r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_base_addr;
  logic [CNT_W-1:0]  w_issue_cnt, w_recv_cnt;
  logic              w_start;
  logic              w_mem_req;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_write_data;
  logic [IDX_W-1:0]  w_word_idx;
  logic              w_write_tag;

  assign w_start = (r_state == IDLE) && bus.miss_detected;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base_addr <= '0;
    end else if (w_start) begin
      r_base_addr <= bus.miss_address & ~OFF_MASK;
    end
  end

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nxt  = r_state;
    w_mem_req    = 1'b0;
    w_mem_addr   = '0;
    w_write_data = 1'b0;
    w_word_idx   = '0;
    w_write_tag  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.miss_detected) w_state_nxt = FILL;
      end
      FILL: begin
        // Request side runs ahead of the responses; the two counters are independent.
        w_mem_req = w_issue_cnt < CNT_W'(LINE_WORDS);
        if (w_mem_req) begin
          w_mem_addr = r_base_addr + ADDR_W'(w_issue_cnt) * ADDR_W'(BYTES_PER_WORD);
        end
        w_write_data = bus.memory_valid;
        w_word_idx   = w_recv_cnt[IDX_W-1:0];
        w_write_tag  = bus.memory_valid && (w_recv_cnt == CNT_W'(LINE_WORDS - 1));
        if (w_write_tag) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  fill_counter #(.W(CNT_W)) u_issue_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start),
    .i_inc   (w_mem_req),
    .o_count (w_issue_cnt)
  );

  fill_counter #(.W(CNT_W)) u_recv_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start),
    .i_inc   (w_write_data),
    .o_count (w_recv_cnt)
  );

  assign bus.fsm_busy         = (r_state == FILL);
  assign bus.mem_req          = w_mem_req;
  assign bus.memory_address   = w_mem_addr;
  assign bus.write_data_array = w_write_data;
  assign bus.fill_word_idx    = w_word_idx;
  assign bus.fill_data        = bus.memory_data_in;
  assign bus.write_tag_array  = w_write_tag;
  assign bus.fill_base_addr   = r_base_addr;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: a queued memory model with fixed or bursty latency.
// Expected requests, writes and tag writes are queued when each miss is driven.
module tb_cache_fill_fsm;
  import cache_fill_fsm_pkg::*;

  typedef struct { int cyc; logic [15:0] addr; } req_t;
  typedef struct { int cyc; logic [2:0] idx; logic [15:0] data; } wr_t;
  typedef struct { int cyc; logic [15:0] base; } tag_t;
  typedef struct { int ready; logic [15:0] addr; } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  cache_fill_fsm_if #(.LINE_WORDS(8), .ADDR_W(16)) bus ();

  cache_fill_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    lat      = 4;
  bit    use_pattern = 1'b0;
  bit    force_valid = 1'b0;
  int    pat_i    = 0;
  int    last_tag_cyc = -100;
  bit    pat [7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  req_t  exp_req_q [$];
  wr_t   exp_wr_q  [$];
  tag_t  exp_tag_q [$];
  pend_t pend_q    [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  // Queue everything a fill starting with the miss sampled at the end of cycle m must produce.
  task automatic push_fill(input logic [15:0] addr, input int m, input bit timed);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      exp_req_q.push_back('{timed ? m + 1 + k : -1, base + 16'(2 * k)});
      exp_wr_q.push_back('{timed ? m + 5 + k : -1, 3'(k), mem_word(base + 16'(2 * k))});
    end
    exp_tag_q.push_back('{timed ? m + 12 : -1, base});
  endtask

  task automatic monitor();
    req_t r;
    wr_t  w;
    tag_t t;
    if (bus.mem_req) begin
      pend_q.push_back('{cyc + lat, bus.memory_address});
      check("req_expected", 32'(exp_req_q.size() != 0), 1);
      if (exp_req_q.size() != 0) begin
        r = exp_req_q.pop_front();
        check("req_addr", bus.memory_address, r.addr);
        if (r.cyc >= 0) check("req_cycle", cyc, r.cyc);
      end
    end else begin
      check("addr_zero_no_req", bus.memory_address, 0);
    end
    if (bus.write_data_array) begin
      check("wr_expected", 32'(exp_wr_q.size() != 0), 1);
      if (exp_wr_q.size() != 0) begin
        w = exp_wr_q.pop_front();
        check("wr_idx", bus.fill_word_idx, w.idx);
        check("wr_data", bus.fill_data, w.data);
        if (w.cyc >= 0) check("wr_cycle", cyc, w.cyc);
      end
    end
    if (bus.write_tag_array) begin
      last_tag_cyc = cyc;
      check("tag_with_data", bus.write_data_array, 1);
      check("tag_expected", 32'(exp_tag_q.size() != 0), 1);
      if (exp_tag_q.size() != 0) begin
        t = exp_tag_q.pop_front();
        check("tag_base", bus.fill_base_addr, t.base);
        if (t.cyc >= 0) check("tag_cycle", cyc, t.cyc);
      end
    end
  endtask

  // One clock cycle: memory inputs change just after the edge, outputs are sampled at negedge.
  task automatic step();
    bit gate;
    @(posedge clk);
    cyc++;
    #1;
    bus.memory_valid   = 1'b0;
    bus.memory_data_in = 16'h0000;
    if (pend_q.size() != 0 && pend_q[0].ready <= cyc) begin
      gate = 1'b1;
      if (use_pattern) begin
        gate  = pat[pat_i % 7];
        pat_i++;
      end
      if (gate) begin
        bus.memory_valid   = 1'b1;
        bus.memory_data_in = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
    end else if (force_valid) begin
      bus.memory_valid   = 1'b1;
      bus.memory_data_in = 16'hDEAD;
    end
    @(negedge clk);
    monitor();
  endtask

  task automatic wait_idle(input int budget, input int exp_idle_cyc);
    for (int i = 0; i < budget; i++) begin
      step();
      if (!bus.fsm_busy) break;
    end
    check("idle_reached", bus.fsm_busy, 0);
    check("busy_drop_after_tag", cyc, last_tag_cyc + 1);
    if (exp_idle_cyc >= 0) check("idle_cycle", cyc, exp_idle_cyc);
    check("req_left", exp_req_q.size(), 0);
    check("wr_left", exp_wr_q.size(), 0);
    check("tag_left", exp_tag_q.size(), 0);
  endtask

  task automatic check_zero(input string tag, input bit with_data);
    check({tag, "_busy"}, bus.fsm_busy, 0);
    check({tag, "_req"}, bus.mem_req, 0);
    check({tag, "_addr"}, bus.memory_address, 0);
    check({tag, "_wda"}, bus.write_data_array, 0);
    check({tag, "_idx"}, bus.fill_word_idx, 0);
    check({tag, "_tag"}, bus.write_tag_array, 0);
    check({tag, "_base"}, bus.fill_base_addr, 0);
    if (with_data) check({tag, "_data"}, bus.fill_data, 0);
  endtask

  task automatic simple_fill(input logic [15:0] addr, input bit timed);
    int m;
    m = cyc;
    push_fill(addr, m, timed);
    bus.miss_detected = 1'b1;
    bus.miss_address  = addr;
    step();
    bus.miss_detected = 1'b0;
    check("fill_busy", bus.fsm_busy, 1);
    check("fill_base", bus.fill_base_addr, addr & 16'hFFF0);
    wait_idle(80, timed ? m + 13 : -1);
  endtask

  initial begin
    int m;
    bus.miss_detected  = 1'b0;
    bus.miss_address   = 16'h0000;
    bus.memory_valid   = 1'b0;
    bus.memory_data_in = 16'h0000;

    repeat (2) @(negedge clk);
    check_zero("reset", 1'b1);
    rst_n = 1'b1;
    step();
    step();

    // Basic fill against the 4-cycle reference timeline.
    simple_fill(16'h1234, 1'b1);

    // Wrap boundary: the last request must stay at 0xFFFE.
    simple_fill(16'hFFF6, 1'b1);

    // Bursty responses.
    lat = 1;
    use_pattern = 1'b1;
    pat_i = 0;
    simple_fill(16'h0A5E, 1'b0);
    lat = 4;
    use_pattern = 1'b0;

    // miss_detected toggling mid-fill is ignored.
    m = cyc;
    push_fill(16'h1234, m, 1'b0);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1234;
    step();
    bus.miss_address = 16'h5000;
    for (int i = 0; i < 6; i++) begin
      bus.miss_detected = (i % 2 == 0);
      step();
      check("busy_base_hold", bus.fill_base_addr, 16'h1230);
    end
    bus.miss_detected = 1'b0;
    wait_idle(80, -1);

    // Spurious memory_valid in IDLE.
    force_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_valid_wda", bus.write_data_array, 0);
      check("idle_valid_busy", bus.fsm_busy, 0);
    end
    force_valid = 1'b0;
    step();

    // Reset in cycle 7 of a fill.
    m = cyc;
    push_fill(16'h1234, m, 1'b0);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1234;
    step();
    bus.miss_detected = 1'b0;
    repeat (6) step();
    check("pre_reset_busy", bus.fsm_busy, 1);
    rst_n = 1'b0;
    #1;
    check_zero("midreset", 1'b0);
    exp_req_q.delete();
    exp_wr_q.delete();
    exp_tag_q.delete();
    pend_q.delete();
    step();
    step();
    check_zero("held_reset", 1'b1);
    rst_n = 1'b1;
    step();
    simple_fill(16'h0040, 1'b1);

    // Back-to-back: the miss stays high through completion with a new address.
    m = cyc;
    push_fill(16'h1234, m, 1'b1);
    push_fill(16'h2008, m + 13, 1'b1);
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1234;
    step();
    bus.miss_address = 16'h2008;
    repeat (12) step();
    check("b2b_gap_idle", bus.fsm_busy, 0);
    check("b2b_first_tag", last_tag_cyc, m + 12);
    step();
    bus.miss_detected = 1'b0;
    check("b2b_second_busy", bus.fsm_busy, 1);
    check("b2b_second_base", bus.fill_base_addr, 16'h2000);
    wait_idle(80, m + 26);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
